// File: rtl/bitorder_pkg.sv
// Shared types and the symbol permutation helper for the bit-order stage.
package bitorder_pkg;

    // Upper bounds for the generic permutation helper; the top refuses larger parameters.
    localparam int MAX_SYM_W  = 8;
    localparam int MAX_WORD_W = 64;
    localparam int SYM_IDX_W  = $clog2(MAX_SYM_W);
    localparam int WORD_IDX_W = $clog2(MAX_WORD_W);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_SYMREV = 2'd1,
        MODE_BITREV = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Output symbol k of a word of n symbols of sym_w bits. Reserved mode behaves as bypass.
    // Bit-reverse mirrors the whole word, so bit b of symbol k is word bit (n*sym_w-1-k*sym_w-b).
    function automatic logic [MAX_SYM_W-1:0] permute_sym(
        input logic [MAX_WORD_W-1:0] word,
        input int unsigned           sym_w,
        input int unsigned           n,
        input int unsigned           k,
        input mode_e                 mode
    );
        logic [MAX_SYM_W-1:0] sym;
        int unsigned          pos;
        sym = '0;
        for (int unsigned b = 0; b < MAX_SYM_W; b++) begin
            case (mode)
                MODE_SYMREV: pos = (n - 1 - k) * sym_w + b;
                MODE_BITREV: pos = n * sym_w - 1 - k * sym_w - b;
                default:     pos = k * sym_w + b;
            endcase
            if (b < sym_w) begin
                sym[b[SYM_IDX_W-1:0]] = word[pos[WORD_IDX_W-1:0]];
            end
        end
        return sym;
    endfunction

endpackage

// File: rtl/bitorder_drain.sv
// Per-buffer output serialiser: walks the N symbols of one completed word, permuted by the
// mode captured at start, and flags the final symbol of the frame.
module bitorder_drain
    import bitorder_pkg::*;
#(
    parameter int SYM_W  = 2,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  mode_e             mode_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              next_done_i,
    output logic              axiov_o,
    output logic [SYM_W-1:0]  axiod_o,
    output logic              axiol_o
);
    localparam int N     = WORD_W / SYM_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic             axiov_q, axiov_d;
    logic [SYM_W-1:0] axiod_q, axiod_d;
    logic             axiol_q, axiol_d;
    logic [MAX_SYM_W-1:0] sym;

    // Emit one symbol per cycle while active; the final symbol is the frame's last unless the
    // next word completes on this very edge (fixed latency makes the two coincide exactly).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        active_d = active_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        axiov_d  = active_q;
        axiod_d  = axiod_q;
        axiol_d  = 1'b0;
        sym      = permute_sym(MAX_WORD_W'(word_i), SYM_W, N, 32'(cnt_q), mode_q);
        if (active_q) begin
            axiod_d = sym[SYM_W-1:0];
            if (cnt_q == CNT_W'(N - 1)) begin
                axiol_d  = !next_done_i;
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mode_d   = mode_i;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= MODE_BYPASS;
            axiov_q  <= 1'b0;
            axiod_q  <= '0;
            axiol_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            axiov_q  <= axiov_d;
            axiod_q  <= axiod_d;
            axiol_q  <= axiol_d;
        end
    end

    assign axiov_o = axiov_q;
    assign axiod_o = axiod_q;
    assign axiol_o = axiol_q;

endmodule

// File: rtl/bitorder_param.sv
// Symbol-to-word collector with ping-pong buffers feeding two drain serialisers. Output
// symbols follow their input symbols by exactly N cycles in every mode.
module bitorder_param
    import bitorder_pkg::*;
#(
    parameter int SYM_W  = 2,
    parameter int WORD_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             axiiv,
    input  logic [SYM_W-1:0] axiid,
    output logic             axiov,
    output logic [SYM_W-1:0] axiod,
    output logic             axiol,
    output logic             err_partial
);
    localparam int N     = WORD_W / SYM_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((WORD_W % SYM_W) != 0 || N < 2 || SYM_W > MAX_SYM_W || WORD_W > MAX_WORD_W)
    begin : g_param_check
        $error("bitorder_param: WORD_W must be a multiple of SYM_W with at least 2 symbols");
    end

    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic              fill_sel_q, fill_sel_d;
    logic              in_frame_q, in_frame_d;
    mode_e             mode_q, mode_d;
    logic [WORD_W-1:0] buf_q [2];
    logic [WORD_W-1:0] buf_d [2];
    logic              err_partial_q, err_partial_d;
    logic              out_sel_q, out_sel_d;
    logic              word_done;
    logic [1:0]        drain_v;
    logic [1:0]        drain_l;
    logic [SYM_W-1:0]  drain_d [2];

    // Fill side: place each symbol into the current buffer, swap buffers on word completion,
    // latch the mode at frame start and drop any partial word when the frame ends.
    always_comb begin
        fill_cnt_d    = fill_cnt_q;
        fill_sel_d    = fill_sel_q;
        mode_d        = mode_q;
        buf_d         = buf_q;
        in_frame_d    = axiiv;
        word_done     = axiiv && (fill_cnt_q == CNT_W'(N - 1));
        err_partial_d = !axiiv && in_frame_q && (fill_cnt_q != '0);
        if (axiiv && !in_frame_q) begin
            mode_d = mode_e'(mode);
        end
        if (axiiv) begin
            buf_d[fill_sel_q][int'(fill_cnt_q) * SYM_W +: SYM_W] = axiid;
            if (word_done) begin
                fill_cnt_d = '0;
                fill_sel_d = !fill_sel_q;
            end else begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end else begin
            fill_cnt_d = '0;
        end
        // Remember which drain spoke last so axiod holds its value while idle.
        out_sel_d = out_sel_q;
        if (drain_v[1]) begin
            out_sel_d = 1'b1;
        end else if (drain_v[0]) begin
            out_sel_d = 1'b0;
        end
    end

    // Fill-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_q    <= '0;
            fill_sel_q    <= 1'b0;
            in_frame_q    <= 1'b0;
            mode_q        <= MODE_BYPASS;
            // NOTE: the word buffers are ordinary flops, so they take the reset like the rest of
            // the state; a RAM-style array would be left unreset instead.
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            err_partial_q <= 1'b0;
            out_sel_q     <= 1'b0;
        end else begin
            fill_cnt_q    <= fill_cnt_d;
            fill_sel_q    <= fill_sel_d;
            in_frame_q    <= in_frame_d;
            mode_q        <= mode_d;
            buf_q         <= buf_d;
            err_partial_q <= err_partial_d;
            out_sel_q     <= out_sel_d;
        end
    end

    // One serialiser per buffer; a buffer's drain starts on the edge its word completes.
    for (genvar g = 0; g < 2; g++) begin : g_drain
        bitorder_drain #(
            .SYM_W  (SYM_W),
            .WORD_W (WORD_W)
        ) u_drain (
            .clk         (clk),
            .rst         (rst),
            .start_i     (word_done && (fill_sel_q == 1'(g))),
            .mode_i      (mode_q),
            .word_i      (buf_q[g]),
            .next_done_i (word_done),
            .axiov_o     (drain_v[g]),
            .axiod_o     (drain_d[g]),
            .axiol_o     (drain_l[g])
        );
    end

    assign axiov       = |drain_v;
    assign axiol       = |drain_l;
    assign axiod       = drain_v[1] ? drain_d[1] :
                         drain_v[0] ? drain_d[0] :
                         (out_sel_q ? drain_d[1] : drain_d[0]);
    assign err_partial = err_partial_q;

endmodule

// File: tb/tb_bitorder_param.sv
// Bench for bitorder_param: a narrow instance (dibit/byte) and a wide one (nibble/32-bit),
// each checked against a scoreboard of expected symbols, last flags and arrival cycles.
module tb_bitorder_param;

    localparam int SW   = 2;
    localparam int WW   = 8;
    localparam int N    = WW / SW;
    localparam int SW_W = 4;
    localparam int WW_W = 32;
    localparam int N_W  = WW_W / SW_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      mode;
    logic            axiiv;
    logic [SW-1:0]   axiid;
    logic            axiov;
    logic [SW-1:0]   axiod;
    logic            axiol;
    logic            err_partial;

    logic [1:0]      mode_w;
    logic            axiiv_w;
    logic [SW_W-1:0] axiid_w;
    logic            axiov_w;
    logic [SW_W-1:0] axiod_w;
    logic            axiol_w;
    logic            err_partial_w;

    bitorder_param #(.SYM_W(SW), .WORD_W(WW)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .axiod(axiod), .axiol(axiol), .err_partial(err_partial)
    );

    bitorder_param #(.SYM_W(SW_W), .WORD_W(WW_W)) u_dut_w (
        .clk(clk), .rst(rst), .mode(mode_w), .axiiv(axiiv_w), .axiid(axiid_w),
        .axiov(axiov_w), .axiod(axiod_w), .axiol(axiol_w), .err_partial(err_partial_w)
    );

    typedef struct {
        logic [7:0] sym;
        logic       last;
        int         due;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] word;
        logic [7:0] exp;   // expected output symbol k in exp[k*SW +: SW]
    } vec_t;

    exp_t sb[$];
    exp_t sb_w[$];
    exp_t e_n;
    exp_t e_w;
    vec_t vecs [8];
    int   cyc      = 0;
    int   err_due  = -1;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: permute the whole word, then slice symbols in order.
    function automatic logic [7:0] model(input logic [7:0] w, input logic [1:0] m);
        logic [7:0] p;
        p = w;
        if (m == 2'd1) begin
            for (int k = 0; k < N; k++) p[k*SW +: SW] = w[(N-1-k)*SW +: SW];
        end else if (m == 2'd2) begin
            for (int i = 0; i < WW; i++) p[i] = w[WW-1-i];
        end
        return p;
    endfunction

    // Narrow-instance monitor.
    always @(negedge clk) begin
        if (axiov) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sym: got axiod=%0h axiol=%0b, required no output (cycle %0d)",
                         axiod, axiol, cyc);
            end else begin
                e_n = sb.pop_front();
                check("axiod", 64'(axiod), 64'(e_n.sym));
                check("axiol", 64'(axiol), 64'(e_n.last));
                check("latency", 64'(cyc), 64'(e_n.due));
            end
        end else begin
            if (axiol) check("axiol_idle", 64'(axiol), 64'd0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                check("axiov_missing", 64'(axiov), 64'd1);
                void'(sb.pop_front());
            end
        end
        if (err_partial || cyc == err_due) check("err_partial", 64'(err_partial), 64'(cyc == err_due));
    end

    // Wide-instance monitor.
    always @(negedge clk) begin
        if (axiov_w) begin
            if (sb_w.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w_unexpected_sym: got axiod=%0h, required no output (cycle %0d)", axiod_w, cyc);
            end else begin
                e_w = sb_w.pop_front();
                check("w_axiod", 64'(axiod_w), 64'(e_w.sym));
                check("w_axiol", 64'(axiol_w), 64'(e_w.last));
                check("w_latency", 64'(cyc), 64'(e_w.due));
            end
        end else if (sb_w.size() != 0 && sb_w[0].due <= cyc) begin
            check("w_axiov_missing", 64'(axiov_w), 64'd1);
            void'(sb_w.pop_front());
        end
        if (err_partial_w) check("w_err_partial", 64'(err_partial_w), 64'd0);
    end

    task automatic send_word(input logic [7:0] w, input logic [7:0] exp, input logic last);
        exp_t t;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) begin
                for (int k = 0; k < N; k++) begin
                    t.sym  = 8'(exp[k*SW +: SW]);
                    t.last = last && (k == N - 1);
                    t.due  = cyc + 1 + N + k;
                    sb.push_back(t);
                end
            end
            axiiv = 1'b1;
            axiid = w[i*SW +: SW];
        end
    endtask

    task automatic send_syms(input logic [7:0] w, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = w[i*SW +: SW];
        end
    endtask

    task automatic idle(input int cnt, input bit expect_err);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (i == 0 && expect_err) err_due = cyc + 1;
            axiiv = 1'b0;
        end
    endtask

    task automatic send_word_w(input logic [31:0] w, input logic [31:0] exp, input logic last);
        exp_t t;
        for (int i = 0; i < N_W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                for (int k = 0; k < N_W; k++) begin
                    t.sym  = 8'(exp[k*SW_W +: SW_W]);
                    t.last = last && (k == N_W - 1);
                    t.due  = cyc + 1 + N_W + k;
                    sb_w.push_back(t);
                end
            end
            axiiv_w = 1'b1;
            axiid_w = w[i*SW_W +: SW_W];
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && sb_w.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", 64'(sb.size() + sb_w.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        mode    = 2'd0;
        axiiv   = 1'b0;
        axiid   = '0;
        mode_w  = 2'd0;
        axiiv_w = 1'b0;
        axiid_w = '0;

        vecs[0] = '{mode: 2'd1, word: 8'h39, exp: 8'h6C};
        vecs[1] = '{mode: 2'd0, word: 8'h39, exp: 8'h39};
        vecs[2] = '{mode: 2'd2, word: 8'h39, exp: 8'h9C};
        vecs[3] = '{mode: 2'd3, word: 8'h39, exp: 8'h39};
        vecs[4] = '{mode: 2'd1, word: 8'hA5, exp: 8'h5A};
        vecs[5] = '{mode: 2'd2, word: 8'hA5, exp: 8'hA5};
        vecs[6] = '{mode: 2'd1, word: 8'h0F, exp: 8'hF0};
        vecs[7] = '{mode: 2'd2, word: 8'h0F, exp: 8'hF0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_axiov", 64'(axiov), 64'd0);
        check("reset_axiod", 64'(axiod), 64'd0);
        check("reset_axiol", 64'(axiol), 64'd0);
        check("reset_err", 64'(err_partial), 64'd0);
        check("reset_w_axiov", 64'(axiov_w), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-word frames in every mode.
        for (int v = 0; v < 8; v++) begin
            mode = vecs[v].mode;
            send_word(vecs[v].word, vecs[v].exp, 1'b1);
            idle(2, 1'b0);
        end
        wait_drain();

        // Three back-to-back words in one frame: contiguous, axiol only on the 12th symbol.
        mode = 2'd1;
        send_word(8'h39, model(8'h39, 2'd1), 1'b0);
        send_word(8'hA5, model(8'hA5, 2'd1), 1'b0);
        send_word(8'h0F, model(8'h0F, 2'd1), 1'b1);
        idle(2, 1'b0);
        wait_drain();

        // One word plus two stray symbols: word drains with axiol, partial flagged once.
        mode = 2'd1;
        send_word(8'h39, 8'h6C, 1'b1);
        send_syms(8'hFF, 2);
        idle(3, 1'b1);
        wait_drain();

        // Frames with no complete word: only the error pulse, at both fill extremes.
        send_syms(8'hC6, 3);
        idle(2, 1'b1);
        send_syms(8'h02, 1);
        idle(2, 1'b1);
        wait_drain();

        // Two frames split by one low cycle; mode changes mid-frame are ignored.
        mode = 2'd1;
        send_word(8'h39, model(8'h39, 2'd1), 1'b0);
        mode = 2'd2;
        send_word(8'hA5, model(8'hA5, 2'd1), 1'b1);
        idle(1, 1'b0);
        send_word(8'h0F, model(8'h0F, 2'd2), 1'b0);
        mode = 2'd0;
        send_word(8'h39, model(8'h39, 2'd2), 1'b1);
        idle(2, 1'b0);
        wait_drain();

        // Reset while a word is draining, then a clean frame.
        mode = 2'd1;
        send_word(8'h39, 8'h6C, 1'b1);
        @(negedge clk);
        axiiv = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_axiov", 64'(axiov), 64'd0);
        check("midrst_axiol", 64'(axiol), 64'd0);
        rst = 1'b0;
        send_word(8'h39, 8'h6C, 1'b1);
        idle(2, 1'b0);
        wait_drain();

        // Wide instance: nibbles of 0x12345678 symbol-reversed, then bit-reversed next frame.
        mode_w = 2'd1;
        send_word_w(32'h12345678, 32'h87654321, 1'b0);
        send_word_w(32'h12345678, 32'h87654321, 1'b1);
        @(negedge clk);
        axiiv_w = 1'b0;
        mode_w  = 2'd2;
        send_word_w(32'h12345678, 32'h1E6A2C48, 1'b1);
        @(negedge clk);
        axiiv_w = 1'b0;
        wait_drain();

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000 ns");
        $fatal(1, "bench timeout");
    end

endmodule
